// File: rtl/placement_pkg.sv
// Shared types and helpers for the streaming graph placer: FSM states,
// ring-search directions, LFSR polynomial and saturating accumulation.
package placement_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLEAR  = 4'd1,
        ST_FETCH  = 4'd2,
        ST_RAND_A = 4'd3,
        ST_NEAR   = 4'd4,
        ST_CHECK  = 4'd5,
        ST_COMMIT = 4'd6,
        ST_ACCUM  = 4'd7,
        ST_DONE   = 4'd8,
        ST_FAIL   = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        DIR_XP = 2'd0,
        DIR_YP = 2'd1,
        DIR_XN = 2'd2,
        DIR_YN = 2'd3
    } dir_e;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } delta_t;

    localparam int unsigned EMPTY_CELL = 0;
    localparam logic [31:0] LFSR_POLY  = 32'hD0000001;

    // Unit step for one ring-search direction; callers scale by the radius.
    function automatic delta_t dir_delta(input dir_e d);
        delta_t r;
        case (d)
            DIR_XP:  r = '{dx: 2'sd1,  dy: 2'sd0};
            DIR_YP:  r = '{dx: 2'sd0,  dy: 2'sd1};
            DIR_XN:  r = '{dx: -2'sd1, dy: 2'sd0};
            DIR_YN:  r = '{dx: 2'sd0,  dy: -2'sd1};
            default: r = '{dx: 2'sd0,  dy: 2'sd0};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/rng_lfsr32.sv
// 32-bit Galois LFSR (shift right, XOR polynomial when the LSB is 1).
// A zero seed is replaced by 1 so the register never locks up.
module rng_lfsr32
    import placement_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value
);

    logic [31:0] lfsr_q, lfsr_d, seed_s;

    assign seed_s = (seed == 32'd0) ? 32'd1 : seed;
    assign value  = lfsr_q;

    // Next LFSR value: advance only when a draw is consumed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed_s;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/placement_stream_engine.sv
// Streaming edge placer: random seed cell for a fresh edge, ring search for its
// partner, incremental wirelength. Optional macro WL_1HOP_EN enables wl_1hop.
module placement_stream_engine
    import placement_pkg::*;
#(
    parameter int          GRID_W    = 8,
    parameter int          GRID_H    = 8,
    parameter int          NODE_W    = 7,
    parameter int          COORD_W   = 8,
    parameter int          MAX_RING  = 4,
    parameter int          MAX_TRIES = 64,
    parameter logic [31:0] SEED      = 32'd147621160
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               edge_valid,
    output logic               edge_ready,
    input  logic [NODE_W-1:0]  edge_a,
    input  logic [NODE_W-1:0]  edge_b,
    input  logic               edge_last,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [31:0]        wl_sum,
    output logic [31:0]        wl_1hop,
    input  logic [NODE_W-1:0]  rd_node,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_placed
);

    localparam int CELLS  = GRID_W * GRID_H;
    localparam int NODES  = 1 << NODE_W;
    localparam int CLR_N  = (CELLS > NODES) ? CELLS : NODES;
    localparam int CLR_W  = $clog2(CLR_N);
    localparam int CELL_W = $clog2(CELLS);
    localparam int RING_W = $clog2(MAX_RING + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);

    typedef struct packed {
        logic               placed;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } node_ent_t;

    state_e              state_q, state_d;
    logic [CLR_W-1:0]    clr_q, clr_d;
    logic [NODE_W-1:0]   a_q, a_d, b_q, b_d, tgt_q, tgt_d;
    logic                last_q, last_d, pend_b_q, pend_b_d, near_q, near_d;
    logic                rand_ph_q, rand_ph_d, near_first_q, near_first_d;
    logic [COORD_W-1:0]  anc_x_q, anc_x_d, anc_y_q, anc_y_d;
    logic [COORD_W-1:0]  cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [RING_W-1:0]   ring_q, ring_d;
    logic [1:0]          dcnt_q, dcnt_d, k_q, k_d, k_eff_s;
    logic [31:0]         wl_sum_q, wl_sum_d, wl_1hop_q, wl_1hop_d, wl_inc_s;
    logic                busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic                edge_ready_q, edge_ready_d;
    logic [COORD_W-1:0]  rd_x_q, rd_y_q;
    logic                rd_placed_q;

    logic [NODE_W:0]     grid_q [CELLS];
    node_ent_t           node_q [NODES];
    logic [NODE_W:0]     cell_q;
    node_ent_t           fa_ent_s, fb_ent_s, acc_a_s, acc_b_s, rd_ent_s;
    logic [CELL_W-1:0]   rd_idx_s, cidx_s;

    logic                rng_step_s;
    logic [31:0]         rng_val_s;
    delta_t              delta_s;
    int                  ncx_i, ncy_i, dx_raw_i, dy_raw_i, adx_i, ady_i, dist_i;
    logic                n_inb_s, near_last_s;

    rng_lfsr32 u_rng (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .step  (rng_step_s),
        .value (rng_val_s)
    );

    assign fa_ent_s = node_q[edge_a];
    assign fb_ent_s = node_q[edge_b];
    assign acc_a_s  = node_q[a_q];
    assign acc_b_s  = node_q[b_q];
    assign rd_ent_s = node_q[rd_node];

    // Ring candidate: anchor plus radius times the unit step of the current direction.
    assign k_eff_s     = near_first_q ? rng_val_s[1:0] : k_q;
    assign delta_s     = dir_delta(dir_e'(k_eff_s + dcnt_q));
    assign ncx_i       = int'(anc_x_q) + int'($signed(delta_s.dx)) * int'(ring_q);
    assign ncy_i       = int'(anc_y_q) + int'($signed(delta_s.dy)) * int'(ring_q);
    assign n_inb_s     = (ncx_i >= 0) && (ncx_i < GRID_W) && (ncy_i >= 0) && (ncy_i < GRID_H);
    assign near_last_s = (dcnt_q == 2'd3) && (int'(ring_q) == MAX_RING);

    assign rd_idx_s = CELL_W'(int'(cand_y_d) * GRID_W + int'(cand_x_d));
    assign cidx_s   = CELL_W'(int'(cand_y_q) * GRID_W + int'(cand_x_q));

    assign dx_raw_i = int'(acc_a_s.x) - int'(acc_b_s.x);
    assign dy_raw_i = int'(acc_a_s.y) - int'(acc_b_s.y);
    assign adx_i    = (dx_raw_i < 0) ? -dx_raw_i : dx_raw_i;
    assign ady_i    = (dy_raw_i < 0) ? -dy_raw_i : dy_raw_i;
    assign dist_i   = adx_i + ady_i;
    assign wl_inc_s = (dist_i > 1) ? 32'(dist_i - 1) : 32'd0;

`ifdef WL_1HOP_EN
    int          hop_i;
    logic [31:0] wl1_inc_s;
    assign hop_i     = (adx_i + 1) / 2 + (ady_i + 1) / 2;
    assign wl1_inc_s = (hop_i > 1) ? 32'(hop_i - 1) : 32'd0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;      clr_q <= '0;
            a_q <= '0;  b_q <= '0;   tgt_q <= '0;
            last_q <= 1'b0;          pend_b_q <= 1'b0;    near_q <= 1'b0;
            rand_ph_q <= 1'b0;       near_first_q <= 1'b0;
            anc_x_q <= '0;  anc_y_q <= '0;  cand_x_q <= '0;  cand_y_q <= '0;
            tries_q <= '0;  ring_q <= '0;   dcnt_q <= 2'd0;  k_q <= 2'd0;
            wl_sum_q <= 32'd0;       wl_1hop_q <= 32'd0;
            busy_q <= 1'b0;  done_q <= 1'b0;  fail_q <= 1'b0;  edge_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;      clr_q <= clr_d;
            a_q <= a_d;  b_q <= b_d; tgt_q <= tgt_d;
            last_q <= last_d;        pend_b_q <= pend_b_d; near_q <= near_d;
            rand_ph_q <= rand_ph_d;  near_first_q <= near_first_d;
            anc_x_q <= anc_x_d;  anc_y_q <= anc_y_d;  cand_x_q <= cand_x_d;  cand_y_q <= cand_y_d;
            tries_q <= tries_d;  ring_q <= ring_d;    dcnt_q <= dcnt_d;      k_q <= k_d;
            wl_sum_q <= wl_sum_d;    wl_1hop_q <= wl_1hop_d;
            busy_q <= busy_d;  done_q <= done_d;  fail_q <= fail_d;  edge_ready_q <= edge_ready_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;  clr_d = clr_q;  a_d = a_q;  b_d = b_q;  tgt_d = tgt_q;
        last_d = last_q;  pend_b_d = pend_b_q;  near_d = near_q;
        rand_ph_d = rand_ph_q;  near_first_d = near_first_q;
        anc_x_d = anc_x_q;  anc_y_d = anc_y_q;  cand_x_d = cand_x_q;  cand_y_d = cand_y_q;
        tries_d = tries_q;  ring_d = ring_q;  dcnt_d = dcnt_q;  k_d = k_q;
        wl_sum_d = wl_sum_q;
`ifdef WL_1HOP_EN
        wl_1hop_d = wl_1hop_q;
`else
        wl_1hop_d = 32'd0;
`endif
        rng_step_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;  clr_d = '0;
                    wl_sum_d = 32'd0;    wl_1hop_d = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (int'(clr_q) == CLR_N - 1) begin
                    state_d = ST_FETCH;
                end else begin
                    clr_d = clr_q + CLR_W'(1);
                end
            end
            ST_FETCH: begin
                if (edge_valid) begin
                    a_d = edge_a;  b_d = edge_b;  last_d = edge_last;
                    tries_d = '0;  rand_ph_d = 1'b0;  pend_b_d = 1'b0;
                    near_first_d = 1'b1;  ring_d = RING_W'(1);  dcnt_d = 2'd0;
                    if (edge_a == edge_b) begin
                        tgt_d = edge_a;  near_d = 1'b0;
                        state_d = fa_ent_s.placed ? ST_ACCUM : ST_RAND_A;
                    end else if (!fa_ent_s.placed && !fb_ent_s.placed) begin
                        tgt_d = edge_a;  near_d = 1'b0;  pend_b_d = 1'b1;  state_d = ST_RAND_A;
                    end else if (fa_ent_s.placed && fb_ent_s.placed) begin
                        state_d = ST_ACCUM;
                    end else if (fa_ent_s.placed) begin
                        tgt_d = edge_b;  near_d = 1'b1;  state_d = ST_NEAR;
                        anc_x_d = fa_ent_s.x;  anc_y_d = fa_ent_s.y;
                    end else begin
                        tgt_d = edge_a;  near_d = 1'b1;  state_d = ST_NEAR;
                        anc_x_d = fb_ent_s.x;  anc_y_d = fb_ent_s.y;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_RAND_A: begin
                rng_step_s = 1'b1;
                if (!rand_ph_q) begin
                    cand_x_d = COORD_W'(rng_val_s % 32'(GRID_W));  rand_ph_d = 1'b1;
                end else begin
                    cand_y_d = COORD_W'(rng_val_s % 32'(GRID_H));  rand_ph_d = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_NEAR: begin
                if (near_first_q) begin
                    rng_step_s = 1'b1;  k_d = rng_val_s[1:0];  near_first_d = 1'b0;
                end else begin
                    k_d = k_q;
                end
                if (n_inb_s) begin
                    cand_x_d = COORD_W'(ncx_i);  cand_y_d = COORD_W'(ncy_i);  state_d = ST_CHECK;
                end else if (near_last_s) begin
                    state_d = ST_FAIL;
                end else if (dcnt_q == 2'd3) begin
                    dcnt_d = 2'd0;  ring_d = ring_q + RING_W'(1);
                end else begin
                    dcnt_d = dcnt_q + 2'd1;
                end
            end
            ST_CHECK: begin
                if (cell_q == (NODE_W+1)'(EMPTY_CELL)) begin
                    state_d = ST_COMMIT;
                end else if (!near_q) begin
                    if (int'(tries_q) == MAX_TRIES - 1) begin
                        state_d = ST_FAIL;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);  state_d = ST_RAND_A;
                    end
                end else if (near_last_s) begin
                    state_d = ST_FAIL;
                end else if (dcnt_q == 2'd3) begin
                    dcnt_d = 2'd0;  ring_d = ring_q + RING_W'(1);  state_d = ST_NEAR;
                end else begin
                    dcnt_d = dcnt_q + 2'd1;  state_d = ST_NEAR;
                end
            end
            ST_COMMIT: begin
                if (pend_b_q) begin
                    pend_b_d = 1'b0;  tgt_d = b_q;  near_d = 1'b1;  near_first_d = 1'b1;
                    ring_d = RING_W'(1);  dcnt_d = 2'd0;
                    anc_x_d = cand_x_q;  anc_y_d = cand_y_q;  state_d = ST_NEAR;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (a_q != b_q) begin
                    wl_sum_d = sat_add32(wl_sum_q, wl_inc_s);
`ifdef WL_1HOP_EN
                    wl_1hop_d = sat_add32(wl_1hop_q, wl1_inc_s);
`endif
                end else begin
                    wl_sum_d = wl_sum_q;
                end
                state_d = last_q ? ST_DONE : ST_FETCH;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAIL:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track it.
    always_comb begin
        busy_d       = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FAIL));
        done_d       = (state_d == ST_DONE);
        fail_d       = (state_d == ST_FAIL);
        edge_ready_d = (state_d == ST_FETCH);
    end

    // Grid and node tables; contents survive reset and are wiped by CLEAR.
    always_ff @(posedge clk) begin
        cell_q <= grid_q[rd_idx_s];
        if (state_q == ST_CLEAR) begin
            if (int'(clr_q) < CELLS) begin
                grid_q[CELL_W'(clr_q)] <= (NODE_W+1)'(EMPTY_CELL);
            end
            if (int'(clr_q) < NODES) begin
                node_q[NODE_W'(clr_q)] <= '0;
            end
        end else if (state_q == ST_COMMIT) begin
            grid_q[cidx_s] <= {1'b0, tgt_q} + (NODE_W+1)'(1);
            node_q[tgt_q]  <= {1'b1, cand_x_q, cand_y_q};
        end
    end

    // Position query port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_x_q <= '0;  rd_y_q <= '0;  rd_placed_q <= 1'b0;
        end else begin
            rd_x_q <= rd_ent_s.x;  rd_y_q <= rd_ent_s.y;  rd_placed_q <= rd_ent_s.placed;
        end
    end

    assign edge_ready = edge_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign wl_sum     = wl_sum_q;
    assign wl_1hop    = wl_1hop_q;
    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign rd_placed  = rd_placed_q;

endmodule

// File: tb/tb_placement_stream_engine.sv
// Directed bench: a 4x4 placer (index 0) for the main flows and a 2x2,
// ring-1 placer (index 1) for the unreachable-cell failure.
module tb_placement_stream_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       reset, start, ev, el, ready, busy, done, fail, rpl;
    logic [1:0][2:0]  ea, eb, rdn;
    logic [1:0][7:0]  rx, ry;
    logic [1:0][31:0] wls, wlh;

    int checks = 0;
    int errors = 0;
    int hs_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};

    placement_stream_engine #(.GRID_W(4), .GRID_H(4), .NODE_W(3), .COORD_W(8),
                              .MAX_RING(4), .MAX_TRIES(64)) u_dut4 (
        .clk(clk), .reset(reset[0]), .start(start[0]),
        .edge_valid(ev[0]), .edge_ready(ready[0]), .edge_a(ea[0]), .edge_b(eb[0]),
        .edge_last(el[0]), .busy(busy[0]), .done(done[0]), .fail(fail[0]),
        .wl_sum(wls[0]), .wl_1hop(wlh[0]), .rd_node(rdn[0]),
        .rd_x(rx[0]), .rd_y(ry[0]), .rd_placed(rpl[0])
    );

    placement_stream_engine #(.GRID_W(2), .GRID_H(2), .NODE_W(2), .COORD_W(8),
                              .MAX_RING(1), .MAX_TRIES(64)) u_dut2 (
        .clk(clk), .reset(reset[1]), .start(start[1]),
        .edge_valid(ev[1]), .edge_ready(ready[1]), .edge_a(ea[1][1:0]), .edge_b(eb[1][1:0]),
        .edge_last(el[1]), .busy(busy[1]), .done(done[1]), .fail(fail[1]),
        .wl_sum(wls[1]), .wl_1hop(wlh[1]), .rd_node(rdn[1][1:0]),
        .rd_x(rx[1]), .rd_y(ry[1]), .rd_placed(rpl[1])
    );

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ev[u] && ready[u]) hs_cnt[u]++;
            if (done[u]) done_cnt[u]++;
        end
    end

    task automatic check_eq(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic pulse_start(input int u);
        @(posedge clk); #1 start[u] = 1'b1;
        @(posedge clk); #1 start[u] = 1'b0;
    endtask

    task automatic send_edge(input int u, input int a, input int b, input bit last);
        int n = 0;
        @(negedge clk);
        ea[u] = 3'(a); eb[u] = 3'(b); el[u] = last; ev[u] = 1'b1;
        while (!ready[u] && n < 400) begin @(negedge clk); n++; end
        check_eq("edge_accepted", (n < 400), 1);
        @(posedge clk); #1 ev[u] = 1'b0;
    endtask

    task automatic wait_end(input int u, output bit got_done, output bit got_fail);
        int n = 0;
        while (!done[u] && !fail[u] && n < 2000) begin @(negedge clk); n++; end
        got_done = done[u]; got_fail = fail[u];
        check_eq("run_ended", (n < 2000), 1);
    endtask

    task automatic wait_ready(input int u, input int bound, output int n);
        n = 0;
        while (!ready[u] && n < bound) begin @(negedge clk); n++; end
    endtask

    task automatic read_node(input int u, input int node, output int x, output int y, output bit pl);
        @(negedge clk); rdn[u] = 3'(node);
        @(negedge clk); x = int'(rx[u]); y = int'(ry[u]); pl = rpl[u];
    endtask

    initial begin
        bit gd, gf, p0, p1;
        int x0, y0, x1, y1, n, hs0, exp_wl, exp_h;
        int px [4];
        int py [4];

        reset = 2'b11; start = '0; ev = '0; el = '0; ea = '0; eb = '0; rdn = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy[0], 0);
        check_eq("rst_ready", ready[0], 0);
        check_eq("rst_done_fail", {done[0], fail[0]}, 0);
        check_eq("rst_wl_sum", wls[0], 0);
        check_eq("rst_wl_1hop", wlh[0], 0);
        check_eq("rst_rd", {rpl[0], rx[0], ry[0]}, 0);
        check_eq("rst_busy_2x2", busy[1], 0);
        reset = 2'b00;

        // single edge (1,2)
        pulse_start(0);
        check_eq("busy_after_start", busy[0], 1);
        hs0 = hs_cnt[0];
        send_edge(0, 1, 2, 1'b1);
        wait_end(0, gd, gf);
        check_eq("t1_done", gd, 1);
        check_eq("t1_fail", gf, 0);
        check_eq("t1_busy_dropped", busy[0], 0);
        check_eq("t1_one_edge", hs_cnt[0] - hs0, 1);
        check_eq("t1_wl_sum", wls[0], 0);
        check_eq("t1_wl_1hop", wlh[0], 0);
        read_node(0, 1, x0, y0, p0);
        read_node(0, 2, x1, y1, p1);
        check_eq("t1_placed", {p0, p1}, 2'b11);
        check_eq("t1_dist", iabs(x0 - x1) + iabs(y0 - y1), 1);

        // chain 0-1, 1-2, 2-3
        pulse_start(0);
        send_edge(0, 0, 1, 1'b0);
        send_edge(0, 1, 2, 1'b0);
        send_edge(0, 2, 3, 1'b1);
        wait_end(0, gd, gf);
        check_eq("t2_done", gd, 1);
        check_eq("t2_wl_sum", wls[0], 0);
        for (int i = 0; i < 4; i++) begin
            read_node(0, i, px[i], py[i], p0);
            check_eq("t2_placed", p0, 1);
        end
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_adjacent", iabs(px[i] - px[i+1]) + iabs(py[i] - py[i+1]), 1);
        end

        // self edge (5,5); CLEAR must have wiped node 1 from earlier runs
        pulse_start(0);
        send_edge(0, 5, 5, 1'b0);
        wait_ready(0, 20, n);
        check_eq("t3_ready_within_10", (n <= 10), 1);
        read_node(0, 5, x0, y0, p0);
        check_eq("t3_self_placed", p0, 1);
        read_node(0, 1, x0, y0, p0);
        check_eq("t3_cleared_node1", p0, 0);
        check_eq("t3_wl_sum", wls[0], 0);
        send_edge(0, 5, 5, 1'b1);
        wait_end(0, gd, gf);
        check_eq("t3_done", gd, 1);
        check_eq("t3_wl_sum_end", wls[0], 0);

        // both endpoints already placed when edge (0,7) arrives
        pulse_start(0);
        send_edge(0, 0, 1, 1'b0);
        send_edge(0, 7, 7, 1'b0);
        send_edge(0, 0, 7, 1'b1);
        wait_end(0, gd, gf);
        check_eq("t5_done", gd, 1);
        read_node(0, 0, x0, y0, p0);
        read_node(0, 7, x1, y1, p1);
        check_eq("t5_placed", {p0, p1}, 2'b11);
        exp_wl = iabs(x0 - x1) + iabs(y0 - y1) - 1;
`ifdef WL_1HOP_EN
        exp_h = (iabs(x0 - x1) + 1) / 2 + (iabs(y0 - y1) + 1) / 2 - 1;
`else
        exp_h = 0;
`endif
        check_eq("t5_wl_sum", wls[0], exp_wl);
        check_eq("t5_wl_1hop", wlh[0], exp_h);

        // 2x2 star: third partner would need the diagonal cell
        pulse_start(1);
        send_edge(1, 0, 1, 1'b0);
        send_edge(1, 0, 2, 1'b0);
        send_edge(1, 0, 3, 1'b1);
        wait_end(1, gd, gf);
        check_eq("t4_fail", gf, 1);
        check_eq("t4_done_absent", gd, 0);
        check_eq("t4_busy_dropped", busy[1], 0);
        check_eq("t4_done_count", done_cnt[1], 0);
        check_eq("t4_wl_sum", wls[1], 0);

        // reset mid-run, then a fresh run starts from empty tables
        pulse_start(0);
        send_edge(0, 3, 4, 1'b0);
        #1 reset[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_rst_busy", busy[0], 0);
        check_eq("t6_rst_ready", ready[0], 0);
        check_eq("t6_rst_wl", wls[0], 0);
        reset[0] = 1'b0;
        @(posedge clk); #1;
        check_eq("t6_idle_after_rst", busy[0], 0);
        pulse_start(0);
        wait_ready(0, 400, n);
        check_eq("t6_fetch_reached", (n < 400), 1);
        for (int i = 0; i < 8; i++) begin
            read_node(0, i, x0, y0, p0);
            check_eq("t6_cleared", p0, 0);
        end
        check_eq("t6_wl_restart", wls[0], 0);
        send_edge(0, 3, 4, 1'b1);
        wait_end(0, gd, gf);
        check_eq("t6_done", gd, 1);
        read_node(0, 3, x0, y0, p0);
        read_node(0, 4, x1, y1, p1);
        check_eq("t6_replaced", {p0, p1}, 2'b11);
        check_eq("t6_pair_adjacent", iabs(x0 - x1) + iabs(y0 - y1), 1);
        read_node(0, 5, x0, y0, p0);
        check_eq("t6_other_unplaced", p0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/placement_stream_engine.md
Name: placement_stream_engine

Overview:
- Parametrised next-generation placer. Accepts a stream of graph edges (a,b) and places each unplaced endpoint on a GRID_W x GRID_H grid.
- The first endpoint of a disconnected edge goes to a random free cell. Its partner goes to the nearest free cell in a randomised ring search.
- Accumulates wirelength incrementally. Positions are readable afterwards through a query port.
- Sits between the edge-list loader and the placement-result dump/evaluation logic.

Parameters:
GRID_W, 8, grid columns (>=2)
GRID_H, 8, grid rows (>=2)
NODE_W, 7, node id width; node capacity 2**NODE_W
COORD_W, 8, coordinate width; must hold max(GRID_W,GRID_H)
MAX_RING, 4, largest ring radius tried by near placement
MAX_TRIES, 64, random-cell draws before failing
SEED, 32'd147621160, RNG reset seed (0 is replaced by 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  pulse in IDLE: clear tables and begin a run
edge_valid  in  1  edge present
edge_ready  out  1  edge accepted when valid&&ready
edge_a  in  NODE_W  source node
edge_b  in  NODE_W  sink node
edge_last  in  1  final edge of run
busy  out  1  high from start until done/fail
done  out  1  one-cycle pulse, run succeeded
fail  out  1  one-cycle pulse, no free cell found
wl_sum  out  32  sum of (|dx|+|dy|-1) over non-self edges
wl_1hop  out  32  sum of (ceil|dx|/2+ceil|dy|/2-1)
rd_node  in  NODE_W  position query address
rd_x  out  COORD_W  x of rd_node, 1-cycle latency
rd_y  out  COORD_W  y of rd_node, 1-cycle latency
rd_placed  out  1  node placed, 1-cycle latency

Behaviour:
- Reset: all outputs 0; state IDLE; RNG = SEED; tables are not cleared (clearing happens on start).
- States: IDLE, CLEAR, FETCH, RAND_A, NEAR, CHECK, COMMIT, ACCUM, DONE, FAIL.
- IDLE + start → CLEAR. busy=1. wl_sum and wl_1hop zeroed.
- CLEAR writes one grid cell and one node entry per cycle. Lasts max(GRID_W*GRID_H, 2**NODE_W) cycles, then → FETCH.
- FETCH: edge_ready=1 only in FETCH. On handshake, latch a, b, last, then look up placed flags.
- a==b: edge skipped, nothing accumulated. Placed if unplaced, like a single node with no partner (RAND_A).
- Case selection after FETCH:
  - Neither endpoint placed → RAND_A for a, then NEAR for b anchored at a.
  - Exactly one placed → NEAR for the other, anchored at the placed one.
  - Both placed → ACCUM.
- RAND_A: two RNG draws per try, x=r%GRID_W then y=r%GRID_H. Occupied cell → redraw. After MAX_TRIES occupied draws → FAIL.
- NEAR:
  - One draw gives k=r%4.
  - Rings r=1..MAX_RING. Within each ring, directions d=k,k+1,k+2,k+3 mod 4, with 0:(+r,0) 1:(0,+r) 2:(-r,0) 3:(0,-r).
  - A candidate is rejected if out of bounds (signed compare, no wrap) or occupied.
  - All candidates exhausted → FAIL.
- CHECK: grid read, 1-cycle latency.
- COMMIT: write grid[y*GRID_W+x]=node id+1 (0 = empty), and node entry {placed,x,y}.
- ACCUM: add both sums in one cycle. |dx| and |dy| are computed in 32-bit signed arithmetic.
  - Adjacent nodes contribute 0.
  - Both sums saturate at 32'hFFFFFFFF.
- After ACCUM: last → DONE, else → FETCH.
- DONE and FAIL pulse their output for 1 cycle, drop busy, → IDLE. Tables and sums hold until the next start.
- start while busy: ignored. reset mid-run: immediate IDLE, outputs 0.
- Query port is always active. Reads during a run may return mid-run values.

Optional Feature:
- Macro WL_1HOP_EN.
- Defined: wl_1hop is computed as above.
- Undefined: wl_1hop is tied to 0 and its adder is removed; all other behaviour is identical.

Decomposition:
- Package placement_pkg: state enum, direction enum and delta function, EMPTY_CELL=0, LFSR_POLY=32'hD0000001.
- Sub-module rng_lfsr32: Galois LFSR, shift right, XOR LFSR_POLY when the LSB is 1.
  - Ports: clk, reset, seed, step, value.
  - Advances one step per draw.

Test Plan:
- 4x4 grid, single edge (1,2): done after exactly one edge. Node 2 is at Manhattan distance 1 from node 1. wl_sum=0, wl_1hop=0.
- 4x4 grid, chain 0-1, 1-2, 2-3 with edge_last on the 3rd: all nodes placed, every pair adjacent, wl_sum=0.
- Self edge (5,5): node 5 placed, wl_sum unchanged, edge_ready back high within 10 cycles.
- 2x2 grid, MAX_RING=1, star edges 0-1, 0-2, 0-3: the 3rd edge needs diagonal (1,1), which is unreachable → fail pulse, busy=0, done never asserted.
- Both endpoints pre-placed: node 0 at (0,0) via edge 0-1, node 7 placed far by a later edge, then edge (0,7) accumulates exact |dx|+|dy|-1, checked against rd_x/rd_y readback.
- Reset asserted mid-run, then start: CLEAR empties the tables. rd_placed=0 for every node until re-placed; sums restart at 0.
